// File: rtl/test_detector_pkg.sv
// Shared types and constants for the detector hit-bus stimulus generator.
package test_detector_pkg;
  localparam int CNTR_WIDTH_DEF = 16;
  localparam int DET_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/test_detector_timer.sv
// Loadable down-counter timing one PULSE or GAP interval; done marks the interval's last cycle.
module test_detector_timer #(
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [CNTR_WIDTH-1:0] value,
  output logic                  done
);
  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  logic [CNTR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt > ONE) begin
      cnt <= cnt - ONE;
    end
  end

  // A loaded 0 behaves like 1, so a zero gap still lasts one cycle.
  assign done = (cnt <= ONE);
endmodule

// File: rtl/test_detector_writer.sv
// Drives programmable pulse trains onto the 64-channel detector hit bus under start/stop control.
module test_detector_writer
  import test_detector_pkg::*;
#(
  parameter int CNTR_WIDTH = CNTR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DET_WIDTH-1:0]  cfg_mask,
  input  logic [CNTR_WIDTH-1:0] cfg_width,
  input  logic [CNTR_WIDTH-1:0] cfg_gap,
  input  logic [CNTR_WIDTH-1:0] cfg_count,
  input  logic                  start,
  input  logic                  stop,
  output logic [DET_WIDTH-1:0]  det_data,
  output logic                  busy,
  output logic [CNTR_WIDTH-1:0] pulse_cntr
);
  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  state_t                state;
  logic [DET_WIDTH-1:0]  mask_q;
  logic [CNTR_WIDTH-1:0] width_q;
  logic [CNTR_WIDTH-1:0] gap_q;
  logic [CNTR_WIDTH-1:0] count_q;
  logic                  accept;
  logic                  last_pulse;
  logic                  t_load;
  logic [CNTR_WIDTH-1:0] t_value;
  logic                  t_done;

  assign accept = start && !stop && (cfg_mask != '0) &&
                  (cfg_width != '0) && (cfg_count != '0);
  // pulse_cntr never exceeds count-1 here, so the increment cannot wrap.
  assign last_pulse = ((pulse_cntr + ONE) == count_q);

  always_comb begin
    t_load  = 1'b0;
    t_value = cfg_width;
    case (state)
      IDLE: begin
        t_load  = accept;
        t_value = cfg_width;
      end
      PULSE: begin
        t_load  = t_done && !last_pulse;
        t_value = gap_q;
      end
      GAP: begin
        t_load  = t_done;
        t_value = width_q;
      end
      default: begin
        t_load  = 1'b0;
        t_value = cfg_width;
      end
    endcase
  end

  test_detector_timer #(.CNTR_WIDTH(CNTR_WIDTH)) u_timer (
    .clk   (aclk),
    .reset (areset),
    .load  (t_load),
    .value (t_value),
    .done  (t_done)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      det_data   <= '0;
      busy       <= 1'b0;
      pulse_cntr <= '0;
      mask_q     <= '0;
      width_q    <= '0;
      gap_q      <= '0;
      count_q    <= '0;
    end else if (stop) begin
      // Abort: a pulse cut short here is deliberately left uncounted.
      state    <= IDLE;
      det_data <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q     <= cfg_mask;
            width_q    <= cfg_width;
            gap_q      <= cfg_gap;
            count_q    <= cfg_count;
            pulse_cntr <= '0;
            busy       <= 1'b1;
            det_data   <= cfg_mask;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (t_done) begin
            pulse_cntr <= pulse_cntr + ONE;
            det_data   <= '0;
            if (last_pulse) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (t_done) begin
            det_data <= mask_q;
            state    <= PULSE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_detector_writer.sv
// Bench for test_detector_writer: expected per-cycle bus traces built from pulse-train rules.
module tb_test_detector_writer;
  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] cfg_mask;
  logic [15:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_count;
  logic        start;
  logic        stop;
  logic [63:0] det_data;
  logic        busy;
  logic [15:0] pulse_cntr;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic        exp_busy_q[$];
  logic [15:0] exp_pc_q[$];

  always #5 aclk = ~aclk;

  test_detector_writer #(.CNTR_WIDTH(16)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_mask   (cfg_mask),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .det_data   (det_data),
    .busy       (busy),
    .pulse_cntr (pulse_cntr)
  );

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic scramble_cfg();
    cfg_mask  = {$urandom, $urandom};
    cfg_width = 16'($urandom);
    cfg_gap   = 16'($urandom);
    cfg_count = 16'($urandom);
  endtask

  // Runs one train and checks every cycle from the first pulse cycle to the first idle cycle.
  // stop_at / restart_at are trace indices at which stop / start are raised (-1 = never).
  task automatic run_check(input string name, input logic [63:0] m, input int w, input int g,
                           input int c, input int stop_at, input int restart_at,
                           output int busy_seen, output logic [15:0] pc_end);
    int gm;
    int n;
    gm = (g == 0) ? 1 : g;
    exp_q.delete();
    exp_busy_q.delete();
    exp_pc_q.delete();
    for (int p = 0; p < c; p++) begin
      for (int j = 0; j < w; j++) begin
        exp_q.push_back(m); exp_busy_q.push_back(1'b1); exp_pc_q.push_back(16'(p));
      end
      if (p < c - 1) begin
        for (int j = 0; j < gm; j++) begin
          exp_q.push_back('0); exp_busy_q.push_back(1'b1); exp_pc_q.push_back(16'(p + 1));
        end
      end
    end
    exp_q.push_back('0); exp_busy_q.push_back(1'b0); exp_pc_q.push_back(16'(c));
    if (stop_at >= 0 && stop_at < exp_q.size() - 1) begin
      pc_end = exp_pc_q[stop_at];
      while (exp_q.size() > stop_at + 1) begin
        void'(exp_q.pop_back()); void'(exp_busy_q.pop_back()); void'(exp_pc_q.pop_back());
      end
      exp_q.push_back('0); exp_busy_q.push_back(1'b0); exp_pc_q.push_back(pc_end);
    end
    pc_end = exp_pc_q[exp_pc_q.size() - 1];

    cfg_mask  = m;
    cfg_width = 16'(w);
    cfg_gap   = 16'(g);
    cfg_count = 16'(c);
    stop      = 1'b0;
    start     = 1'b1;
    busy_seen = 0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if (busy) busy_seen++;
      total++;
      if (det_data !== exp_q[i] || busy !== exp_busy_q[i] || pulse_cntr !== exp_pc_q[i]) begin
        bad++;
        $display("FAIL %s idx=%0d got det=%h busy=%b pc=%0d exp det=%h busy=%b pc=%0d",
                 name, i, det_data, busy, pulse_cntr, exp_q[i], exp_busy_q[i], exp_pc_q[i]);
      end
      stop  = (i == stop_at);
      start = (i == restart_at);
      scramble_cfg();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_mask = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
    repeat (3) next_cycle();
    total++;
    if (det_data !== 64'h0 || busy !== 1'b0 || pulse_cntr !== 16'h0) begin
      bad++;
      $display("FAIL reset got det=%h busy=%b pc=%0d exp 0/0/0", det_data, busy, pulse_cntr);
    end
    areset = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_run();
    cfg_mask = '1; cfg_width = 16'd2; cfg_gap = 16'd1; cfg_count = 16'd5;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    total++;
    if (det_data !== '1 || busy !== 1'b1 || pulse_cntr !== 16'd1) begin
      bad++;
      $display("FAIL midrun_pre got det=%h busy=%b pc=%0d exp all-ones/1/1", det_data, busy, pulse_cntr);
    end
    areset = 1'b1;
    next_cycle();
    total++;
    if (det_data !== 64'h0 || busy !== 1'b0 || pulse_cntr !== 16'h0) begin
      bad++;
      $display("FAIL midrun_reset got det=%h busy=%b pc=%0d exp 0/0/0", det_data, busy, pulse_cntr);
    end
    areset = 1'b0;
    next_cycle();
  endtask

  task automatic test_directed();
    int bs;
    logic [15:0] pc;
    repeat (9) next_cycle();
    run_check("single", 64'h0000_0001_0000_0000, 16, 0, 1, -1, -1, bs, pc);
    total++;
    if (bs !== 16 || pc !== 16'd1) begin
      bad++; $display("FAIL single_len got busy=%0d pc=%0d exp 16/1", bs, pc);
    end
    run_check("train", 64'hFFFF_0000_0000_0000, 3, 5, 4, -1, -1, bs, pc);
    total++;
    if (bs !== 27 || pc !== 16'd4) begin
      bad++; $display("FAIL train_len got busy=%0d pc=%0d exp 27/4", bs, pc);
    end
    run_check("zero_gap", 64'h0000_0000_0000_00F0, 2, 0, 3, -1, -1, bs, pc);
    total++;
    if (bs !== 8) begin
      bad++; $display("FAIL zero_gap_len got busy=%0d exp 8", bs);
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 4; k++) begin
      cfg_mask  = (k == 0) ? 64'h0 : 64'h00FF_00FF_00FF_00FF;
      cfg_width = (k == 1) ? 16'd0 : 16'd3;
      cfg_gap   = 16'd2;
      cfg_count = (k == 2) ? 16'd0 : 16'd2;
      start = 1'b1;
      stop  = (k == 3);
      next_cycle();
      start = 1'b0;
      stop  = 1'b0;
      for (int j = 0; j < 3; j++) begin
        total++;
        if (det_data !== 64'h0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL illegal case=%0d cyc=%0d got det=%h busy=%b exp 0/0", k, j, det_data, busy);
        end
        if (j < 2) next_cycle();
      end
    end
  endtask

  task automatic test_abort_rearm();
    int bs;
    logic [15:0] pc;
    // Pulse 3 begins at index 12; stop in its second cycle, with a stray start at index 5.
    run_check("abort", 64'hA5A5_5A5A_0F0F_F0F0, 4, 2, 10, 13, 5, bs, pc);
    total++;
    if (pc !== 16'd2) begin
      bad++; $display("FAIL abort_pc got pc=%0d exp 2", pc);
    end
    run_check("rearm", 64'h0000_0000_0000_0003, 2, 1, 2, -1, -1, bs, pc);
    total++;
    if (pc !== 16'd2 || bs !== 5) begin
      bad++; $display("FAIL rearm_len got busy=%0d pc=%0d exp 5/2", bs, pc);
    end
  endtask

  task automatic test_random();
    int bs;
    logic [15:0] pc;
    for (int r = 0; r < 25; r++) begin
      logic [63:0] m;
      int w, g, c, len, s, rs;
      m = {$urandom, $urandom};
      if (m == 64'h0) m = 64'h1;
      w = $urandom_range(1, 6);
      g = $urandom_range(0, 4);
      c = $urandom_range(1, 6);
      len = c * w + (c - 1) * ((g == 0) ? 1 : g);
      s  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      rs = ($urandom_range(0, 1) == 0) ? $urandom_range(0, len - 1) : -1;
      run_check("random", m, w, g, c, s, rs, bs, pc);
      if (s < 0) begin
        total++;
        if (bs !== len || pc !== 16'(c)) begin
          bad++; $display("FAIL random_len run=%0d got busy=%0d pc=%0d exp %0d/%0d", r, bs, pc, len, c);
        end
      end
      repeat ($urandom_range(0, 3)) next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_directed();
    test_illegal();
    test_abort_rearm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/test_detector_writer.md
Name: test_detector_writer

Overview:
- Stimulus generator driving the 64-channel detector hit bus (det_data) with programmable pulse trains, for bench and loop-back testing of the detector readout path.
- Emits cfg_count pulses on every channel selected by cfg_mask: each pulse cfg_width cycles high, separated by cfg_gap cycles low.
- Controlled by start/stop strobes; reports busy and the number of pulses emitted.

Parameters:
- CNTR_WIDTH, 16, width of the width, gap and count configuration fields and of the counters.

Ports:
- aclk  in  1  system clock.
- areset  in  1  reset; synchronous, active-high.
- cfg_mask  in  64  channels to pulse.
- cfg_width  in  CNTR_WIDTH  pulse high time, cycles.
- cfg_gap  in  CNTR_WIDTH  low time between pulses, cycles.
- cfg_count  in  CNTR_WIDTH  number of pulses per run.
- start  in  1  single-cycle run request.
- stop  in  1  abort request.
- det_data  out  64  detector hit bus, registered.
- busy  out  1  high while a run is in progress, registered.
- pulse_cntr  out  CNTR_WIDTH  pulses completed in the current or last run.

Behaviour:
- Reset (areset high at an aclk edge): det_data=0, busy=0, pulse_cntr=0, state IDLE, all internal counters 0. Reset overrides everything, including mid-run.
- FSM states: IDLE, PULSE, GAP.
- IDLE:
  - det_data=0, busy=0.
  - start is accepted only if cfg_mask!=0, cfg_width!=0, cfg_count!=0 and stop=0; otherwise it is ignored.
  - On accept at edge k: latch mask, width, gap and count; pulse_cntr<=0; busy<=1; det_data<=mask; go to PULSE.
  - Result: det_data is high in the cycle after start is sampled (latency 1).
- PULSE:
  - det_data holds the latched mask for exactly width cycles.
  - On the last cycle: pulse_cntr increments.
  - If pulse_cntr+1==count, go to IDLE: det_data<=0, busy<=0.
  - Otherwise go to GAP: det_data<=0.
- GAP:
  - det_data=0 for max(gap,1) cycles. A gap of 0 is treated as 1, so every pulse has a visible falling edge.
  - Then return to PULSE with det_data<=mask.
- Configuration inputs are sampled only at accept; changes mid-run have no effect.
- start while busy: ignored, no restart.
- stop:
  - Any state: next edge goes to IDLE with det_data<=0 and busy<=0.
  - pulse_cntr keeps its value; a pulse cut short by stop is not counted.
  - start and stop in the same cycle: stop wins.
- Counters:
  - Internal width/gap counter counts down from the latched value to 1.
  - All comparisons are CNTR_WIDTH-bit unsigned.
  - count=2^CNTR_WIDTH-1 must complete without pulse_cntr wrap.
- Total run length for an uninterrupted run: count*width + (count-1)*max(gap,1) cycles.

Decomposition:
- Package test_detector_pkg holds:
  - state encoding enum (IDLE=0, PULSE=1, GAP=2, 2 bits);
  - default CNTR_WIDTH constant;
  - DET_WIDTH=64 constant.
- One natural sub-module, test_detector_timer:
  - loadable CNTR_WIDTH down-counter;
  - inputs: load, value; output: done, asserted when the count reaches 1 or the loaded value is 0/1.
  - Used for both the PULSE and GAP intervals.

Test Plan:
- Reset mid-run: assert areset during PULSE with mask=all ones -> next cycle det_data=0, busy=0, pulse_cntr=0.
- Single pulse: mask=64'h0000_0001_0000_0000, width=16, count=1, start at cycle 10 -> det_data=mask for cycles 11..26, busy high for cycles 11..26, then 0; pulse_cntr=1.
- Train: mask=64'hFFFF_0000_0000_0000, width=3, gap=5, count=4 -> four 3-cycle pulses with 5-cycle gaps, 27 busy cycles, pulse_cntr=4.
- Zero gap: width=2, gap=0, count=3 -> pattern 11 0 11 0 11, busy 8 cycles.
- Illegal start: mask=0, or width=0, or count=0 -> busy stays 0, det_data stays 0. start+stop in the same cycle -> ignored.
- Abort and re-arm: stop in the 2nd cycle of pulse 3 (width=4, gap=2, count=10) -> det_data=0 and busy=0 the next cycle, pulse_cntr=2. Start asserted while busy -> ignored. New start after abort -> pulse_cntr cleared and the run restarts.
